wdt_win: RTL and testbench
==========================

# wdt_win

Parametrised windowed watchdog timer with prescaler, early-warning flag, two-stage timeout (interrupt, then reset request) and an optional service window. It replaces the fixed 32-bit watchdog in peripheral subsystems. Software kicks it through a register-file wrapper, and `rst_req` feeds the SoC reset controller.

## Interface
- `WIDTH`, 32: timer/load/threshold width (8..32)
- `PSC_W`, 8: prescaler width
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `en` in 1: watchdog enable (level)
- `load` in WIDTH: reload value
- `psc` in PSC_W: prescale divisor minus one (0 = tick every cycle)
- `warn_lvl` in WIDTH: early-warning threshold
- `win_lvl` in WIDTH: window-open threshold (only with `WDT_WINDOW_EN`)
- `kick` in 1: service pulse, one cycle per kick
- `ov_clr` in 1: clears `ov`
- `warn_clr` in 1: clears `warn`
- `tmr` out WIDTH: current down-count
- `ov` out 1: sticky first-timeout flag
- `warn` out 1: sticky early-warning flag
- `win_err` out 1: sticky early-kick flag (only with `WDT_WINDOW_EN`)
- `rst_req` out 1: reset request, held until `rst_n`

## Operation
- Reset values: `tmr`=0, `ov`=0, `warn`=0, `win_err`=0, `rst_req`=0. State is IDLE, prescaler count `pc`=0.
- The prescaler advances only in RUN and EXPIRED. A `tick` occurs in any cycle with `pc==psc`; on that cycle `pc` returns to 0, otherwise it increments.
- States:
  - IDLE: `tmr`=0, `pc`=0. If `en`=1, load `tmr`←`load` and go to RUN.
  - RUN: on `tick` with `tmr`≠0, `tmr`←`tmr`−1. On `tick` with `tmr`==0 (expiry), set `ov`, set `tmr`←`load` and go to EXPIRED.
  - EXPIRED: counts the same way as RUN. An expiry here sets `rst_req` and goes to RST_REQ. If `ov_clr` is asserted without a same-cycle expiry, go back to RUN.
  - RST_REQ: terminal. `tmr` frozen, all inputs ignored, left only through `rst_n`.
- `en`=0 in RUN or EXPIRED sends the block to IDLE with `tmr`=0. `ov` and `warn` keep their values.
- `kick` in RUN or EXPIRED: `tmr`←`load`, `pc`←0. A kick does not clear `ov`.
- `warn` sets on a `tick` that decrements `tmr` to exactly `warn_lvl`. It is cleared by `warn_clr`.
- Priority rules:
  - `kick` beats a `tick` in the same cycle.
  - A flag set beats its clear in the same cycle.
  - `en`=0 beats `kick`.
- Arithmetic is modulo 2^WIDTH. The decrement never wraps, because it is gated by `tmr`≠0.
- `load`=0: every tick is an expiry.

## Timing
- `en` rises while IDLE, sampled at edge N: `tmr`==`load` after edge N.
- With divisor P=`psc`, the first decrement lands at edge N+P+1, then one decrement every P+1 cycles.
- Expiry period from load value L is (L+1)·(P+1) cycles, with no kick.
- `ov` and `rst_req` assert at the expiry edge; the reload lands on the same edge.
- `kick` sampled at edge K: `tmr`==`load` after K.

## Configuration
- `WDT_WINDOW_EN` defined:
  - Adds `win_lvl` and `win_err`.
  - A `kick` while `tmr`>`win_lvl` is an early kick. It does not reload. Instead it sets `win_err` and counts as an immediate expiry: RUN→EXPIRED with `ov` set, or EXPIRED→RST_REQ.
  - `win_err` clears only on `rst_n`.
- `WDT_WINDOW_EN` undefined: both ports are absent, and every kick is accepted.

## Structure
- Package `wdt_pkg`:
  - state enum `wdt_state_t` (IDLE, RUN, EXPIRED, RST_REQ)
  - default constants `WDT_WIDTH`=32, `WDT_PSC_W`=8
- Sub-module `wdt_prescaler`: parameter `PSC_W`, inputs `clk`, `rst_n`, `run`, `restart`, `psc`, output `tick`. It clears `pc` when `run`=0 or `restart`=1.

## Test plan
- `WIDTH`=16, `psc`=0, `load`=5, `en` rises at edge 0 → `tmr` counts 5,4,3,2,1,0; `ov`=1 and `tmr`=5 after edge 6. No `ov_clr`, so a second expiry at edge 12 gives `rst_req`=1, held until `rst_n`.
- `psc`=3, `load`=2 → first decrement at edge 4, expiry at edge 12.
- `load`=10, `kick` pulses every 6 cycles → `ov` never set. Deassert `en` mid-count → `tmr`=0 next cycle; kicks in IDLE are ignored.
- `warn_lvl`=3, `load`=8, with `warn_clr` pulsed in the cycle `tmr` reaches 3 → `warn` stays 1 (set beats clear). A later `warn_clr` clears it.
- With `WDT_WINDOW_EN`: `win_lvl`=4, `load`=10.
  - Kick at `tmr`=7 → `win_err`=1, `ov`=1, no reload.
  - After `ov_clr`, a kick at `tmr`=3 → accepted, `tmr`=10.
- Async `rst_n` low while in RST_REQ → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared definitions for the windowed watchdog timer.
// Contents: the FSM state encoding and the default timer and prescaler widths.
// Optional feature macro used by wdt_win: WDT_WINDOW_EN (adds the service window).
package wdt_pkg;

    localparam int unsigned WDT_WIDTH = 32;
    localparam int unsigned WDT_PSC_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2,
        RST_REQ = 2'd3
    } wdt_state_t;

endpackage

// File: rtl/wdt_prescaler.sv
// Cycle prescaler for the watchdog. It produces one tick every psc+1 cycles
// while run is high.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   run        : count enable; the count is held at 0 while low
//   restart    : synchronous clear of the count (service kick)
//   psc        : divisor minus one (0 = tick every cycle)
//   tick       : high in any running cycle where the count equals psc
module wdt_prescaler
    import wdt_pkg::*;
#(
    parameter int unsigned PSC_W = WDT_PSC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] pc_q;
    logic [PSC_W-1:0] pc_d;

    assign tick = run && (pc_q == psc);

    // Next count: clear when stopped, restarted or wrapping, else increment
    always_comb begin
        pc_d = pc_q;
        if (!run || restart) begin
            pc_d = '0;
        end else if (pc_q == psc) begin
            pc_d = '0;
        end else begin
            pc_d = pc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/wdt_win.sv
// Windowed watchdog timer with a prescaler, an early-warning flag and a
// two-stage timeout. The first expiry raises ov. A second expiry without an
// ov_clr in between raises rst_req, which is held until rst_n.
// Build option: define WDT_WINDOW_EN to add win_lvl/win_err. A kick that
// arrives while tmr > win_lvl is then treated as an immediate expiry.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   en                : watchdog enable (level)
//   load              : reload value
//   psc               : prescale divisor minus one
//   warn_lvl          : early-warning threshold
//   win_lvl           : window-open threshold (WDT_WINDOW_EN only)
//   kick              : service pulse
//   ov_clr, warn_clr  : flag clears
//   tmr               : current down-count
//   ov, warn          : sticky timeout and warning flags
//   win_err           : sticky early-kick flag (WDT_WINDOW_EN only)
//   rst_req           : reset request to the SoC reset controller
module wdt_win
    import wdt_pkg::*;
#(
    parameter int unsigned WIDTH = WDT_WIDTH,
    parameter int unsigned PSC_W = WDT_PSC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] load,
    input  logic [PSC_W-1:0] psc,
    input  logic [WIDTH-1:0] warn_lvl,
`ifdef WDT_WINDOW_EN
    input  logic [WIDTH-1:0] win_lvl,
`endif
    input  logic             kick,
    input  logic             ov_clr,
    input  logic             warn_clr,
    output logic [WIDTH-1:0] tmr,
    output logic             ov,
    output logic             warn,
`ifdef WDT_WINDOW_EN
    output logic             win_err,
`endif
    output logic             rst_req
);

    wdt_state_t       state_q, state_d;
    logic [WIDTH-1:0] tmr_q, tmr_d;
    logic             ov_q, ov_d;
    logic             warn_q, warn_d;
    logic             rst_req_q, rst_req_d;
`ifdef WDT_WINDOW_EN
    logic             win_err_q, win_err_d;
`endif

    logic             run_c;
    logic             restart_c;
    logic             tick_c;
    logic             expire_c;

    assign run_c = (state_q == RUN) || (state_q == EXPIRED);

    wdt_prescaler #(
        .PSC_W (PSC_W)
    ) u_psc (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run_c),
        .restart (restart_c),
        .psc     (psc),
        .tick    (tick_c)
    );

    // Next-state logic; flag clears come first so that same-cycle sets win
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        ov_d      = ov_q;
        warn_d    = warn_q;
        rst_req_d = rst_req_q;
`ifdef WDT_WINDOW_EN
        win_err_d = win_err_q;
`endif
        restart_c = 1'b0;
        expire_c  = 1'b0;

        if (state_q != RST_REQ) begin
            if (ov_clr) begin
                ov_d = 1'b0;
            end
            if (warn_clr) begin
                warn_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (en) begin
                    tmr_d   = load;
                    state_d = RUN;
                end
            end

            RUN, EXPIRED: begin
                if (!en) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    if (kick) begin
`ifdef WDT_WINDOW_EN
                        // Early kick: no reload, escalate instead
                        if (tmr_q > win_lvl) begin
                            win_err_d = 1'b1;
                            expire_c  = 1'b1;
                        end else begin
                            tmr_d     = load;
                            restart_c = 1'b1;
                        end
`else
                        tmr_d     = load;
                        restart_c = 1'b1;
`endif
                    end else if (tick_c) begin
                        if (tmr_q != '0) begin
                            tmr_d = tmr_q - WIDTH'(1);
                            if (tmr_d == warn_lvl) begin
                                warn_d = 1'b1;
                            end
                        end else begin
                            expire_c = 1'b1;
                            tmr_d    = load;
                        end
                    end

                    if (expire_c) begin
                        if (state_q == RUN) begin
                            ov_d    = 1'b1;
                            state_d = EXPIRED;
                        end else begin
                            rst_req_d = 1'b1;
                            state_d   = RST_REQ;
                        end
                    end else if (ov_clr && (state_q == EXPIRED)) begin
                        state_d = RUN;
                    end
                end
            end

            RST_REQ: begin
                state_d = RST_REQ;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            ov_q      <= 1'b0;
            warn_q    <= 1'b0;
            rst_req_q <= 1'b0;
`ifdef WDT_WINDOW_EN
            win_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            ov_q      <= ov_d;
            warn_q    <= warn_d;
            rst_req_q <= rst_req_d;
`ifdef WDT_WINDOW_EN
            win_err_q <= win_err_d;
`endif
        end
    end

    assign tmr     = tmr_q;
    assign ov      = ov_q;
    assign warn    = warn_q;
    assign rst_req = rst_req_q;
`ifdef WDT_WINDOW_EN
    assign win_err = win_err_q;
`endif

endmodule

// File: tb/tb_wdt_win.sv
// Bench for wdt_win (WIDTH=16). Cycle vectors carry inputs plus the outputs
// expected after the following clock edge; expectations go through a queue.
module tb_wdt_win;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  load;
    logic [PW-1:0] psc;
    logic [W-1:0]  warn_lvl;
    logic          kick;
    logic          ov_clr;
    logic          warn_clr;
    logic [W-1:0]  tmr;
    logic          ov;
    logic          warn;
    logic          rst_req;
`ifdef WDT_WINDOW_EN
    logic [W-1:0]  win_lvl;
    logic          win_err;
`endif

    wdt_win #(
        .WIDTH (W),
        .PSC_W (PW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .psc      (psc),
        .warn_lvl (warn_lvl),
`ifdef WDT_WINDOW_EN
        .win_lvl  (win_lvl),
`endif
        .kick     (kick),
        .ov_clr   (ov_clr),
        .warn_clr (warn_clr),
        .tmr      (tmr),
        .ov       (ov),
        .warn     (warn),
`ifdef WDT_WINDOW_EN
        .win_err  (win_err),
`endif
        .rst_req  (rst_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          kick;
        logic          ov_clr;
        logic          warn_clr;
        logic [W-1:0]  load;
        logic [PW-1:0] psc;
        logic [W-1:0]  warn_lvl;
        logic [W-1:0]  e_tmr;
        logic          e_ov;
        logic          e_warn;
        logic          e_win;
        logic          e_rr;
    } vec_t;

    typedef struct {
        logic [W-1:0] tmr;
        logic         ov;
        logic         warn;
        logic         win;
        logic         rr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int NOWARN = 16'hFFFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic void add(input bit e, input bit k, input bit oc, input bit wc,
                                input int ld, input int ps, input int wl,
                                input int t, input bit o, input bit wn, input bit we, input bit rr);
        vec_t v;
        v.en = e; v.kick = k; v.ov_clr = oc; v.warn_clr = wc;
        v.load = W'(ld); v.psc = PW'(ps); v.warn_lvl = W'(wl);
        v.e_tmr = W'(t); v.e_ov = o; v.e_warn = wn; v.e_win = we; v.e_rr = rr;
        vecs.push_back(v);
    endfunction

    // Apply queued vectors one per cycle, compare just after each edge
    task automatic run_vecs(input string tag);
        int n;
        n = vecs.size();
        for (int i = 0; i < n; i++) begin
            vec_t v;
            exp_t e;
            exp_t got;
            v = vecs[i];
            @(negedge clk);
            en = v.en; kick = v.kick; ov_clr = v.ov_clr; warn_clr = v.warn_clr;
            load = v.load; psc = v.psc; warn_lvl = v.warn_lvl;
            e.tmr = v.e_tmr; e.ov = v.e_ov; e.warn = v.e_warn; e.win = v.e_win; e.rr = v.e_rr;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            chk($sformatf("%s[%0d].tmr", tag, i), 32'(tmr), 32'(got.tmr));
            chk($sformatf("%s[%0d].ov", tag, i), 32'(ov), 32'(got.ov));
            chk($sformatf("%s[%0d].warn", tag, i), 32'(warn), 32'(got.warn));
            chk($sformatf("%s[%0d].rst_req", tag, i), 32'(rst_req), 32'(got.rr));
`ifdef WDT_WINDOW_EN
            chk($sformatf("%s[%0d].win_err", tag, i), 32'(win_err), 32'(got.win));
`endif
        end
        vecs.delete();
        @(negedge clk);
        kick = 1'b0; ov_clr = 1'b0; warn_clr = 1'b0;
    endtask

    // Assert rst_n between edges and check outputs clear before any clock
    task automatic async_reset(input string tag);
        @(negedge clk);
        en = 1'b0; kick = 1'b0; ov_clr = 1'b0; warn_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, ".tmr"}, 32'(tmr), 32'd0);
        chk({tag, ".ov"}, 32'(ov), 32'd0);
        chk({tag, ".warn"}, 32'(warn), 32'd0);
        chk({tag, ".rst_req"}, 32'(rst_req), 32'd0);
`ifdef WDT_WINDOW_EN
        chk({tag, ".win_err"}, 32'(win_err), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; kick = 1'b0; ov_clr = 1'b0; warn_clr = 1'b0;
        load = '0; psc = '0; warn_lvl = W'(NOWARN);
`ifdef WDT_WINDOW_EN
        win_lvl = W'(16'hFFFF);
`endif
        repeat (2) @(negedge clk);
        chk("reset.tmr", 32'(tmr), 32'd0);
        chk("reset.ov", 32'(ov), 32'd0);
        chk("reset.warn", 32'(warn), 32'd0);
        chk("reset.rst_req", 32'(rst_req), 32'd0);
        rst_n = 1'b1;

        // Kicks every 6 cycles keep ov clear; en=0 beats kick; kicks in IDLE ignored
        add(1,0,0,0, 10,0,NOWARN, 10,0,0,0,0);
        for (int g = 0; g < 3; g++) begin
            for (int t = 9; t >= 5; t--) add(1,0,0,0, 10,0,NOWARN, t,0,0,0,0);
            add(1,1,0,0, 10,0,NOWARN, 10,0,0,0,0);
        end
        add(1,0,0,0, 10,0,NOWARN, 9,0,0,0,0);
        add(1,0,0,0, 10,0,NOWARN, 8,0,0,0,0);
        add(0,1,0,0, 10,0,NOWARN, 0,0,0,0,0);
        add(0,1,0,0, 10,0,NOWARN, 0,0,0,0,0);
        run_vecs("kick");

        // Warning set beats same-cycle clear; warn survives en=0; later clear works
        add(1,0,0,0, 8,0,3, 8,0,0,0,0);
        for (int t = 7; t >= 4; t--) add(1,0,0,0, 8,0,3, t,0,0,0,0);
        add(1,0,0,1, 8,0,3, 3,0,1,0,0);
        add(1,0,0,0, 8,0,3, 2,0,1,0,0);
        add(0,0,0,0, 8,0,3, 0,0,1,0,0);
        add(0,0,0,1, 8,0,3, 0,0,0,0,0);
        run_vecs("warn");

        // psc=3 load=2: decrement at edge 4, expiry at 12; ov_clr returns to RUN
        for (int c = 0; c <= 27; c++) begin
            int t;
            bit o;
            bit e;
            bit oc;
            bit k;
            e = 1'b1; oc = 1'b0; k = 1'b0;
            if (c < 4) t = 2;
            else if (c < 8) t = 1;
            else if (c < 12) t = 0;
            else if (c < 16) t = 2;
            else if (c < 20) t = 1;
            else if (c < 24) t = 0;
            else t = 2;
            o = (c >= 12 && c < 13) || (c >= 24 && c < 27);
            if (c == 13) oc = 1'b1;
            if (c >= 25) begin e = 1'b0; t = 0; end
            if (c == 26) k = 1'b1;
            if (c == 27) oc = 1'b1;
            add(e,k,oc,0, 2,3,NOWARN, t,o,0,0,0);
        end
        run_vecs("psc");

        // psc=0 load=5: expiry at edge 6, reset request at edge 12, held
        add(1,0,0,0, 5,0,NOWARN, 5,0,0,0,0);
        for (int t = 4; t >= 0; t--) add(1,0,0,0, 5,0,NOWARN, t,0,0,0,0);
        add(1,0,0,0, 5,0,NOWARN, 5,1,0,0,0);
        for (int t = 4; t >= 0; t--) add(1,0,0,0, 5,0,NOWARN, t,1,0,0,0);
        add(1,0,0,0, 5,0,NOWARN, 5,1,0,0,1);
        add(0,1,1,1, 5,0,NOWARN, 5,1,0,0,1);
        add(1,0,0,0, 5,0,NOWARN, 5,1,0,0,1);
        run_vecs("expire");

        async_reset("rstreq_reset");

        // Back in IDLE, then load=0: every tick is an expiry
        add(0,0,0,0, 0,0,NOWARN, 0,0,0,0,0);
        add(1,0,0,0, 0,0,NOWARN, 0,0,0,0,0);
        add(1,0,0,0, 0,0,NOWARN, 0,1,0,0,0);
        add(1,0,0,0, 0,0,NOWARN, 0,1,0,0,1);
        run_vecs("load0");

        async_reset("load0_reset");

`ifdef WDT_WINDOW_EN
        // win_lvl=4 load=10: early kick at 7 escalates, kick at 3 accepted
        win_lvl = W'(4);
        add(1,0,0,0, 10,0,NOWARN, 10,0,0,0,0);
        add(1,0,0,0, 10,0,NOWARN, 9,0,0,0,0);
        add(1,0,0,0, 10,0,NOWARN, 8,0,0,0,0);
        add(1,0,0,0, 10,0,NOWARN, 7,0,0,0,0);
        add(1,1,0,0, 10,0,NOWARN, 7,1,0,1,0);
        add(1,0,1,0, 10,0,NOWARN, 6,0,0,1,0);
        add(1,0,0,0, 10,0,NOWARN, 5,0,0,1,0);
        add(1,0,0,0, 10,0,NOWARN, 4,0,0,1,0);
        add(1,0,0,0, 10,0,NOWARN, 3,0,0,1,0);
        add(1,1,0,0, 10,0,NOWARN, 10,0,0,1,0);
        add(1,0,0,0, 10,0,NOWARN, 9,0,0,1,0);
        run_vecs("window");
        async_reset("window_reset");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
